// File: rtl/apb_master_bridge_if.sv
// Bundle of the core-side request/response signals and the APB bus signals
// of apb_master_bridge; "master" is the bridge view, "slave" the far side.
interface apb_master_bridge_if #(
    parameter int NUM_SLV = 4
);
    logic                   i_transfer;
    logic [31:0]            i_addr;
    logic                   i_write;
    logic [31:0]            i_wdata;
    logic                   o_busy;
    logic                   o_ready;
    logic [31:0]            o_rdata;
    logic                   o_err;
    logic [31:0]            PADDR;
    logic                   PWRITE;
    logic [31:0]            PWDATA;
    logic                   PENABLE;
    logic [NUM_SLV-1:0]     PSEL;
    logic [NUM_SLV*32-1:0]  PRDATA_S;
    logic [NUM_SLV-1:0]     PREADY_S;

    modport master (
        input  i_transfer, i_addr, i_write, i_wdata, PRDATA_S, PREADY_S,
        output o_busy, o_ready, o_rdata, o_err,
        output PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );

    modport slave (
        output i_transfer, i_addr, i_write, i_wdata, PRDATA_S, PREADY_S,
        input  o_busy, o_ready, o_rdata, o_err,
        input  PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: turns single-cycle core requests into SETUP/ACCESS transfers,
// decodes one PSEL per 4 KiB slave window and aborts slaves that never answer.
module apb_master_bridge #(
    parameter int          NUM_SLV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic PCLK,
    input  logic PRESET,
    apb_master_bridge_if.master bus
);

    localparam logic [4:0] NUM_SLV_W = 5'(NUM_SLV);
    localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t               state_p0, state_d;
    logic [7:0]           cnt_p0, cnt_d;
    logic [3:0]           idx_p0, idx_n;
    logic                 write_p0;
    logic                 hit, start;
    logic                 rdy_sel;
    logic [31:0]          rdata_sel;
    logic [NUM_SLV-1:0]   psel_n;
    logic                 done_err;
    logic [31:0]          done_rdata;

    assign hit   = (bus.i_addr[31:16] == BASE_ADDR[31:16]) &&
                   ({1'b0, bus.i_addr[15:12]} < NUM_SLV_W);
    assign idx_n = (state_p0 == IDLE) ? bus.i_addr[15:12] : idx_p0;

    // Only the addressed slave's PREADY/PRDATA are observed.
    always_comb begin
        rdy_sel   = 1'b0;
        rdata_sel = '0;
        psel_n    = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (idx_p0 == 4'(k)) begin
                rdy_sel   = bus.PREADY_S[k];
                rdata_sel = bus.PRDATA_S[32*k +: 32];
            end
            if (idx_n == 4'(k)) psel_n[k] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_p0;
        cnt_d      = cnt_p0;
        start      = 1'b0;
        done_err   = 1'b0;
        done_rdata = '0;
        unique case (state_p0)
            IDLE: begin
                if (bus.i_transfer) begin
                    if (hit) begin
                        state_d = SETUP;
                        start   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d  = DONE;
                        done_err = 1'b1;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // PREADY wins over the timeout on the last allowed cycle.
                if (rdy_sel) begin
                    state_d    = DONE;
                    done_rdata = write_p0 ? '0 : rdata_sel;
                end else if (cnt_p0 >= CNT_LAST) begin
                    state_d  = DONE;
                    done_err = 1'b1;
                end else begin
                    cnt_d = cnt_p0 + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (start) begin
            idx_p0   <= bus.i_addr[15:12];
            write_p0 <= bus.i_write;
        end
    end

    // Registered outputs follow the state being entered.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_p0    <= IDLE;
            cnt_p0      <= '0;
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
            bus.PADDR   <= '0;
            bus.PWRITE  <= 1'b0;
            bus.PWDATA  <= '0;
            bus.o_busy  <= 1'b0;
            bus.o_ready <= 1'b0;
            bus.o_rdata <= '0;
            bus.o_err   <= 1'b0;
        end else begin
            state_p0    <= state_d;
            cnt_p0      <= cnt_d;
            bus.PSEL    <= (state_d == SETUP || state_d == ACCESS) ? psel_n : '0;
            bus.PENABLE <= (state_d == ACCESS);
            bus.o_busy  <= (state_d != IDLE);
            bus.o_ready <= (state_d == DONE);
            bus.o_rdata <= done_rdata;
            bus.o_err   <= done_err;
            if (start) begin
                bus.PADDR  <= bus.i_addr;
                bus.PWRITE <= bus.i_write;
                bus.PWDATA <= bus.i_write ? bus.i_wdata : '0;
            end else if (state_d == IDLE) begin
                bus.PWDATA <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: four APB slaves modelled by per-cycle
// PREADY schedules and fixed read data, TIMEOUT=16.
module tb_apb_master_bridge;

    logic PCLK;
    logic PRESET;
    int   vectors;
    int   miscompares;

    apb_master_bridge_if #(.NUM_SLV(4)) bif ();

    apb_master_bridge #(
        .NUM_SLV(4),
        .BASE_ADDR(32'h1000_0000),
        .TIMEOUT(16)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .bus(bif)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic req(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
        bif.i_transfer = 1'b1;
        bif.i_addr     = addr;
        bif.i_write    = wr;
        bif.i_wdata    = wd;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        bif.i_transfer = 1'b0; bif.i_addr = '0; bif.i_write = 1'b0; bif.i_wdata = '0;
        bif.PREADY_S = '0;
        bif.PRDATA_S = {32'h0000_DDDD, 32'h0000_CCCC, 32'h0000_1234, 32'hAAAA_0000};
        tick(); tick();
        vectors++;
        if ({bif.PSEL, bif.PENABLE, bif.PWRITE, bif.o_busy, bif.o_ready, bif.o_err} !== 9'b0) begin
            miscompares++;
            $display("FAIL rst_ctrl: got %b, want 0", {bif.PSEL, bif.PENABLE, bif.PWRITE, bif.o_busy, bif.o_ready, bif.o_err});
        end
        vectors++;
        if ({bif.PADDR, bif.PWDATA, bif.o_rdata} !== 96'b0) begin
            miscompares++;
            $display("FAIL rst_data: got %h %h %h, want 0", bif.PADDR, bif.PWDATA, bif.o_rdata);
        end
        PRESET = 1'b0;
        tick();
        vectors++;
        if (bif.o_busy !== 1'b0) begin miscompares++; $display("FAIL rst_idle_busy: got %b, want 0", bif.o_busy); end
    endtask

    task automatic test_write_hit();
        bif.PREADY_S = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) req(32'h1000_0004, 1'b1, 32'h0000_0001);
            else bif.i_transfer = 1'b0;
            tick();
            if (c + 1 == 1) begin
                vectors++;
                if ({bif.PSEL, bif.PENABLE, bif.PWRITE} !== 6'b0001_0_1) begin
                    miscompares++; $display("FAIL wr_setup: got psel=%b en=%b wr=%b, want 0001 0 1", bif.PSEL, bif.PENABLE, bif.PWRITE);
                end
                vectors++;
                if (bif.PADDR !== 32'h1000_0004 || bif.PWDATA !== 32'h1) begin
                    miscompares++; $display("FAIL wr_addr_data: got %h %h, want 10000004 00000001", bif.PADDR, bif.PWDATA);
                end
            end
            if (c + 1 == 2) begin
                vectors++;
                if ({bif.PSEL, bif.PENABLE, bif.o_ready} !== 6'b0001_1_0) begin
                    miscompares++; $display("FAIL wr_access: got psel=%b en=%b rdy=%b, want 0001 1 0", bif.PSEL, bif.PENABLE, bif.o_ready);
                end
            end
            if (c + 1 == 3) begin
                vectors++;
                if ({bif.o_ready, bif.o_err, bif.PSEL, bif.PENABLE} !== 7'b1_0_0000_0) begin
                    miscompares++; $display("FAIL wr_done: got rdy=%b err=%b psel=%b en=%b, want 1 0 0000 0", bif.o_ready, bif.o_err, bif.PSEL, bif.PENABLE);
                end
            end
            if (c + 1 == 4) begin
                vectors++;
                if ({bif.o_ready, bif.o_busy} !== 2'b00 || bif.PWDATA !== 32'h0 || bif.PADDR !== 32'h1000_0004) begin
                    miscompares++; $display("FAIL wr_idle: got rdy=%b busy=%b pwdata=%h paddr=%h, want 0 0 0 10000004", bif.o_ready, bif.o_busy, bif.PWDATA, bif.PADDR);
                end
            end
        end
    endtask

    task automatic test_read_wait();
        for (int c = 0; c < 6; c++) begin
            if (c == 0) req(32'h1000_1004, 1'b0, 32'hDEAD_BEEF);
            else bif.i_transfer = 1'b0;
            bif.PREADY_S = (c == 2) ? 4'b1101 : (c == 3) ? 4'b0010 : 4'b0000;
            tick();
            if (c + 1 == 1) begin
                vectors++;
                if (bif.PSEL !== 4'b0010 || bif.PWDATA !== 32'h0 || bif.PWRITE !== 1'b0) begin
                    miscompares++; $display("FAIL rd_setup: got psel=%b pwdata=%h wr=%b, want 0010 0 0", bif.PSEL, bif.PWDATA, bif.PWRITE);
                end
            end
            if (c + 1 == 3) begin
                vectors++;
                if ({bif.o_ready, bif.PENABLE} !== 2'b01) begin
                    miscompares++; $display("FAIL rd_wait: got rdy=%b en=%b, want 0 1", bif.o_ready, bif.PENABLE);
                end
            end
            if (c + 1 == 4) begin
                vectors++;
                if (bif.o_ready !== 1'b1 || bif.o_rdata !== 32'h0000_1234 || bif.o_err !== 1'b0) begin
                    miscompares++; $display("FAIL rd_done: got rdy=%b rdata=%h err=%b, want 1 00001234 0", bif.o_ready, bif.o_rdata, bif.o_err);
                end
            end
        end
        bif.PREADY_S = '0;
    endtask

    task automatic test_decode_miss();
        logic [31:0] addrs [3];
        addrs[0] = 32'h1000_5000;
        addrs[1] = 32'h2000_0000;
        addrs[2] = 32'h1000_4000;
        for (int a = 0; a < 3; a++) begin
            int psel_seen;
            psel_seen = 0;
            req(addrs[a], 1'b1, 32'h5A5A_5A5A);
            tick();
            bif.i_transfer = 1'b0;
            if (bif.PSEL !== 4'b0) psel_seen++;
            vectors++;
            if ({bif.o_ready, bif.o_err} !== 2'b11 || bif.o_rdata !== 32'h0) begin
                miscompares++; $display("FAIL miss_done[%0d]: got rdy=%b err=%b rdata=%h, want 1 1 0", a, bif.o_ready, bif.o_err, bif.o_rdata);
            end
            tick();
            if (bif.PSEL !== 4'b0) psel_seen++;
            vectors++;
            if (psel_seen !== 0 || bif.PADDR !== 32'h1000_1004 || bif.PWDATA !== 32'h0 || {bif.o_ready, bif.o_busy} !== 2'b00) begin
                miscompares++; $display("FAIL miss_quiet[%0d]: got psel_cycles=%0d paddr=%h pwdata=%h rdy=%b busy=%b, want 0 10001004 0 0 0",
                                        a, psel_seen, bif.PADDR, bif.PWDATA, bif.o_ready, bif.o_busy);
            end
        end
    endtask

    task automatic test_timeout();
        int access_n, ready_n;
        logic err_at;
        logic [31:0] rdata_at;
        logic [3:0] psel_at;
        access_n = 0; ready_n = -1; err_at = 1'b0; rdata_at = 'x; psel_at = 'x;
        bif.PREADY_S = '0;
        for (int c = 0; c < 25; c++) begin
            if (c == 0) req(32'h1000_2000, 1'b0, 32'h0);
            else bif.i_transfer = 1'b0;
            tick();
            if (bif.PENABLE === 1'b1) access_n++;
            if (bif.o_ready === 1'b1 && ready_n < 0) begin
                ready_n = c + 1; err_at = bif.o_err; rdata_at = bif.o_rdata; psel_at = bif.PSEL;
            end
        end
        vectors++;
        if (access_n !== 16) begin miscompares++; $display("FAIL to_access_len: got %0d, want 16", access_n); end
        vectors++;
        if (ready_n !== 18) begin miscompares++; $display("FAIL to_ready_cycle: got %0d, want 18", ready_n); end
        vectors++;
        if (err_at !== 1'b1 || rdata_at !== 32'h0 || psel_at !== 4'b0) begin
            miscompares++; $display("FAIL to_done: got err=%b rdata=%h psel=%b, want 1 0 0000", err_at, rdata_at, psel_at);
        end
        // follow-up read to slave 0 completes normally
        ready_n = -1;
        bif.PREADY_S = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) req(32'h1000_0010, 1'b0, 32'h0);
            else bif.i_transfer = 1'b0;
            tick();
            if (bif.o_ready === 1'b1 && ready_n < 0) begin
                ready_n = c + 1; err_at = bif.o_err; rdata_at = bif.o_rdata;
            end
        end
        vectors++;
        if (ready_n !== 3 || err_at !== 1'b0 || rdata_at !== 32'hAAAA_0000) begin
            miscompares++; $display("FAIL to_recover: got cycle=%0d err=%b rdata=%h, want 3 0 aaaa0000", ready_n, err_at, rdata_at);
        end
        bif.PREADY_S = '0;
    endtask

    task automatic test_pready_at_limit();
        int access_n, ready_n;
        logic err_at;
        logic [31:0] rdata_at;
        access_n = 0; ready_n = -1; err_at = 1'bx; rdata_at = 'x;
        for (int c = 0; c < 22; c++) begin
            if (c == 0) req(32'h1000_3000, 1'b0, 32'h0);
            else bif.i_transfer = 1'b0;
            bif.PREADY_S = (c == 17) ? 4'b1000 : 4'b0000;
            tick();
            if (bif.PENABLE === 1'b1) access_n++;
            if (bif.o_ready === 1'b1 && ready_n < 0) begin
                ready_n = c + 1; err_at = bif.o_err; rdata_at = bif.o_rdata;
            end
        end
        vectors++;
        if (access_n !== 16 || ready_n !== 18) begin
            miscompares++; $display("FAIL limit_timing: got access=%0d ready_cycle=%0d, want 16 18", access_n, ready_n);
        end
        vectors++;
        if (err_at !== 1'b0 || rdata_at !== 32'h0000_DDDD) begin
            miscompares++; $display("FAIL limit_success: got err=%b rdata=%h, want 0 0000dddd", err_at, rdata_at);
        end
        bif.PREADY_S = '0;
    endtask

    task automatic test_back_to_back();
        int setups, readys;
        logic [3:0] psel_c6;
        logic rdy_c4, rdy_c8;
        logic [31:0] rdata_c8;
        setups = 0; readys = 0; psel_c6 = 'x; rdy_c4 = 1'b0; rdy_c8 = 1'b0; rdata_c8 = 'x;
        for (int c = 0; c < 11; c++) begin
            bif.i_transfer = 1'b0;
            case (c)
                0: req(32'h1000_0008, 1'b1, 32'h0000_0055);
                2: req(32'h1000_1000, 1'b0, 32'h0);
                4: req(32'h1000_1000, 1'b0, 32'h0);
                5: req(32'h1000_1000, 1'b0, 32'h0);
                default: ;
            endcase
            bif.PREADY_S = (c == 3) ? 4'b0001 : (c >= 5) ? 4'b0010 : 4'b0000;
            tick();
            if (bif.PSEL !== 4'b0 && bif.PENABLE === 1'b0) setups++;
            if (bif.o_ready === 1'b1) readys++;
            if (c + 1 == 4) rdy_c4 = bif.o_ready;
            if (c + 1 == 6) psel_c6 = bif.PSEL;
            if (c + 1 == 8) begin rdy_c8 = bif.o_ready; rdata_c8 = bif.o_rdata; end
        end
        vectors++;
        if (setups !== 2 || readys !== 2) begin
            miscompares++; $display("FAIL b2b_counts: got setups=%0d readys=%0d, want 2 2", setups, readys);
        end
        vectors++;
        if (rdy_c4 !== 1'b1 || psel_c6 !== 4'b0010) begin
            miscompares++; $display("FAIL b2b_accept: got rdy@4=%b psel@6=%b, want 1 0010", rdy_c4, psel_c6);
        end
        vectors++;
        if (rdy_c8 !== 1'b1 || rdata_c8 !== 32'h0000_1234) begin
            miscompares++; $display("FAIL b2b_second: got rdy@8=%b rdata=%h, want 1 00001234", rdy_c8, rdata_c8);
        end
        bif.PREADY_S = '0;
    endtask

    task automatic test_reset_mid();
        int readys, ready_n;
        logic [31:0] rdata_at;
        readys = 0; ready_n = -1; rdata_at = 'x;
        bif.PREADY_S = '0;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) req(32'h1000_2004, 1'b1, 32'h1357_9BDF);
            else bif.i_transfer = 1'b0;
            PRESET = (c == 3);
            tick();
        end
        PRESET = 1'b0;
        vectors++;
        if ({bif.PSEL, bif.PENABLE, bif.PWRITE, bif.o_busy, bif.o_ready, bif.o_err} !== 9'b0 ||
            {bif.PADDR, bif.PWDATA, bif.o_rdata} !== 96'b0) begin
            miscompares++; $display("FAIL rstmid_outputs: got psel=%b en=%b busy=%b paddr=%h pwdata=%h, want all 0",
                                    bif.PSEL, bif.PENABLE, bif.o_busy, bif.PADDR, bif.PWDATA);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bif.o_ready === 1'b1 || bif.o_busy === 1'b1) readys++;
        end
        vectors++;
        if (readys !== 0) begin miscompares++; $display("FAIL rstmid_no_ready: got %0d active cycles, want 0", readys); end
        bif.PREADY_S = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) req(32'h1000_0000, 1'b0, 32'h0);
            else bif.i_transfer = 1'b0;
            tick();
            if (bif.o_ready === 1'b1 && ready_n < 0) begin ready_n = c + 1; rdata_at = bif.o_rdata; end
        end
        vectors++;
        if (ready_n !== 3 || rdata_at !== 32'hAAAA_0000) begin
            miscompares++; $display("FAIL rstmid_next: got cycle=%0d rdata=%h, want 3 aaaa0000", ready_n, rdata_at);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_write_hit();
        test_read_wait();
        test_decode_miss();
        test_timeout();
        test_pready_at_limit();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB initiator that converts single-cycle transfer requests from the RISC-V core's data-memory port into APB SETUP/ACCESS transactions on the peripheral bus. It sits between the core and the APB peripherals (FND, GPIO, UART and so on). It decodes the address to one PSEL per slave, waits on the selected slave's PREADY, and returns read data with a completion pulse. It also reports decode errors and ACCESS-phase timeouts so that a hung peripheral cannot stall the core forever.

## Interface
Parameters:
- NUM_SLV, 4: number of APB slaves (1–16).
- BASE_ADDR, 32'h1000_0000: peripheral region base; bits [31:16] are compared.
- TIMEOUT, 16: maximum number of ACCESS cycles without PREADY before the transfer is aborted (2–255).

Ports:
- PCLK, in, 1: the single clock.
- PRESET, in, 1: reset. It is synchronous and active-high.
- i_transfer, in, 1: request strobe, one cycle wide. It is sampled only in IDLE.
- i_addr, in, 32: byte address.
- i_write, in, 1: 1 = write, 0 = read.
- i_wdata, in, 32: write data.
- o_busy, out, 1: high whenever the state is not IDLE.
- o_ready, out, 1: completion pulse, one cycle wide.
- o_rdata, out, 32: read data. Valid only while o_ready=1.
- o_err, out, 1: error flag (decode error or timeout). Valid only while o_ready=1.
- PADDR, out, 32: APB address.
- PWRITE, out, 1: APB direction.
- PWDATA, out, 32: APB write data.
- PENABLE, out, 1: APB enable.
- PSEL, out, NUM_SLV: one-hot slave select.
- PRDATA_S, in, NUM_SLV*32: slave read data; slave k occupies bits [32k+31:32k].
- PREADY_S, in, NUM_SLV: slave ready, one bit per slave.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- **IDLE:**
  - If i_transfer=1, latch i_addr, i_write and i_wdata, then decode.
  - Decode hit requires both i_addr[31:16]==BASE_ADDR[31:16] and idx=i_addr[15:12] < NUM_SLV.
  - On a hit, go to SETUP.
  - On a miss, go to DONE with the error flag set. No APB signal toggles.
- **SETUP (1 cycle):**
  - PSEL[idx]=1, PENABLE=0.
  - PADDR = latched address.
  - PWRITE = latched direction.
  - PWDATA = latched wdata on writes, 0 on reads.
  - Next state is ACCESS.
- **ACCESS:**
  - PSEL[idx]=1, PENABLE=1. PADDR, PWRITE and PWDATA are held stable.
  - PREADY_S[idx]=1 completes the transfer: capture PRDATA_S[idx] (reads only; writes capture 0), clear the error flag, go to DONE.
  - Otherwise increment the wait counter.
  - When the counter reaches TIMEOUT-1 with PREADY still low, abort: set the error flag, capture 0 as read data, go to DONE.
  - PREADY_S of non-selected slaves is ignored.
- **DONE (1 cycle):**
  - o_ready=1.
  - o_rdata = captured data; o_err = error flag.
  - PSEL=0, PENABLE=0.
  - Next state is IDLE.
- Outside DONE, o_rdata=0 and o_err=0.
- PADDR and PWRITE keep their last values between transfers. PWDATA returns to 0 in IDLE.
- The wait counter is 8 bits wide. It clears on entry to SETUP and never wraps, because it is bounded by TIMEOUT.
- While o_busy=1, i_transfer is ignored; the request is dropped, not queued. The requester must wait for o_ready.
- **Reset:**
  - All outputs go to 0: PSEL, PENABLE, PADDR, PWRITE, PWDATA, o_busy, o_ready, o_rdata, o_err.
  - The FSM goes to IDLE and the counter to 0.
  - Reset mid-transfer deasserts PSEL and PENABLE on the next edge, and no o_ready is issued for the aborted transfer.

## Timing
- All outputs are registered.
- **Cycle sequence for a hit, with i_transfer high in cycle 0:**
  - Cycle 1: SETUP.
  - Cycle 2: first ACCESS.
  - PREADY high in ACCESS cycle n (n≥2): o_ready in cycle n+1.
  - Zero-wait slave: o_ready in cycle 3.
  - Slave with one registered PREADY: o_ready in cycle 4.
- Decode miss: o_ready with o_err=1 in cycle 1.
- Timeout: ACCESS lasts exactly TIMEOUT cycles (cycles 2 … TIMEOUT+1), and o_ready with o_err=1 follows in cycle TIMEOUT+2.
- Back-to-back: the earliest next acceptance is the cycle after o_ready (first IDLE cycle). A strobe coincident with o_ready is ignored.
- PREADY arriving in the same cycle the counter hits TIMEOUT-1 counts as success; PREADY has priority over timeout.

## Test plan
- **Write hit:** i_addr=0x1000_0004, i_write=1, i_wdata=0x0000_0001 to slave 0, PREADY held high. Expect:
  - PSEL=0001, PENABLE 0 then 1, PADDR=0x1000_0004, PWDATA=1.
  - o_ready in cycle 3, o_err=0.
- **Read with one wait state:** i_addr=0x1000_1004 to slave 1, which returns PREADY one cycle late with PRDATA=0x0000_1234. Expect:
  - PSEL=0010.
  - o_ready in cycle 4, o_rdata=0x1234, o_err=0.
- **Decode miss:** i_addr=0x1000_5000 and, separately, i_addr=0x2000_0000. Expect:
  - PSEL stays 0 throughout.
  - o_ready in cycle 1, o_err=1, o_rdata=0.
- **Timeout:** slave 2 never raises PREADY, TIMEOUT=16. Expect:
  - ACCESS lasts 16 cycles.
  - o_ready in cycle 18, o_err=1, o_rdata=0, PSEL=0.
  - A following read to slave 0 completes normally.
- **Busy drop:** pulse i_transfer again during ACCESS of the first transfer. Expect:
  - Only one APB transaction and one o_ready pulse.
  - A new strobe in the cycle after o_ready is accepted.
- **Reset mid-ACCESS:** assert PRESET for 1 cycle during ACCESS. Expect:
  - All outputs 0 on the next edge.
  - No o_ready pulse.
  - FSM in IDLE, and the next request runs normally.
